// File: rtl/aes_word_cnt_csr_if.sv
// Avalon-MM slave bus bundle for the word-count CSR block.
interface aes_word_cnt_csr_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );
endinterface

// File: rtl/aes_word_cnt_csr.sv
// Snoops the generator/adder/remover stream handshakes and exposes saturating
// word counts plus a CTRL register over an Avalon-MM slave with read latency 1.
module aes_word_cnt_csr #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CNT_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h1000)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                msg_valid,
  input  logic                msg_ready,
  input  logic                adder_valid,
  input  logic                adder_ready,
  input  logic                remover_valid,
  input  logic                remover_ready,
  aes_word_cnt_csr_if.slave   avs
);

  logic [2:0]        ev;
  logic              hit;
  logic [1:0]        sel;
  logic              wr_hit;
  logic              clr_all;
  logic [CNT_W-1:0]  cnt [3];
  logic [2:0]        ovf;
  logic              en;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] readdata_q;
  logic              readdatavalid_q;
  logic              unused_wdata;

  assign ev      = {remover_valid & remover_ready,
                    adder_valid   & adder_ready,
                    msg_valid     & msg_ready};
  assign hit     = (avs.avs_address[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]) &&
                   (avs.avs_address[1:0] == 2'b00);
  assign sel     = avs.avs_address[3:2];
  assign wr_hit  = avs.avs_write & hit;
  assign clr_all = wr_hit && (sel == 2'd3) && avs.avs_writedata[1];

  assign unused_wdata = ^avs.avs_writedata[DATA_W-1:2];

  // Misses decode to zero so the master always gets a response.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (sel)
        2'd0: begin
          rd_val[CNT_W-1:0] = cnt[0];
          rd_val[DATA_W-1]  = ovf[0];
        end
        2'd1: begin
          rd_val[CNT_W-1:0] = cnt[1];
          rd_val[DATA_W-1]  = ovf[1];
        end
        2'd2: begin
          rd_val[CNT_W-1:0] = cnt[2];
          rd_val[DATA_W-1]  = ovf[2];
        end
        default: rd_val[0] = en;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      ovf             <= '0;
      en              <= 1'b1;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= avs.avs_read;
      if (avs.avs_read) begin
        readdata_q <= rd_val;
      end
      if (wr_hit && (sel == 2'd3)) begin
        en <= avs.avs_writedata[0];
      end
      // Clear wins over the old count but a same-cycle event still lands as 1.
      for (int unsigned i = 0; i < 3; i++) begin
        if (clr_all || (wr_hit && (sel == 2'(i)))) begin
          cnt[i] <= (ev[i] && en) ? CNT_W'(1) : '0;
          ovf[i] <= 1'b0;
        end else if (ev[i] && en) begin
          if (cnt[i] == '1) begin
            ovf[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign avs.avs_readdata      = readdata_q;
  assign avs.avs_readdatavalid = readdatavalid_q;
  assign avs.avs_waitrequest   = 1'b0;

endmodule

// File: tb/tb_aes_word_cnt_csr.sv
// Directed and randomized bench for aes_word_cnt_csr against an arithmetic register model.
module tb_aes_word_cnt_csr;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic msg_valid = 1'b0, msg_ready = 1'b0;
  logic adder_valid = 1'b0, adder_ready = 1'b0;
  logic remover_valid = 1'b0, remover_ready = 1'b0;

  always #5 clk = ~clk;

  aes_word_cnt_csr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avs ();

  aes_word_cnt_csr #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .BASE_ADDR(32'h1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .adder_valid  (adder_valid),
    .adder_ready  (adder_ready),
    .remover_valid(remover_valid),
    .remover_ready(remover_ready),
    .avs          (avs)
  );

  int          errors = 0;
  int          checks = 0;
  int          m_cnt[3];
  bit          m_ovf[3];
  bit          m_en;
  logic [31:0] exp_rd;
  bit          exp_rdv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    int k;
    v = 0;
    if (a[31:4] == 28'h100 && a[1:0] == 2'b00) begin
      k = int'(a[3:2]);
      if (k == 3) v = m_en ? 32'd1 : 32'd0;
      else v = (m_ovf[k] ? 32'h8000_0000 : 32'd0) + 32'(m_cnt[k]);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
    end
    m_en    = 1;
    exp_rd  = 0;
    exp_rdv = 0;
  endtask

  task automatic model_update();
    bit ev[3];
    bit clr[3];
    bit hit;
    int k;
    bit new_en;
    ev[0] = msg_valid && msg_ready;
    ev[1] = adder_valid && adder_ready;
    ev[2] = remover_valid && remover_ready;
    hit = avs.avs_address[31:4] == 28'h100 && avs.avs_address[1:0] == 2'b00;
    k = int'(avs.avs_address[3:2]);
    new_en = m_en;
    for (int i = 0; i < 3; i++) clr[i] = 0;
    if (avs.avs_write && hit) begin
      if (k == 3) begin
        new_en = avs.avs_writedata[0];
        if (avs.avs_writedata[1]) for (int i = 0; i < 3; i++) clr[i] = 1;
      end else begin
        clr[k] = 1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (clr[i]) begin
        m_cnt[i] = (ev[i] && m_en) ? 1 : 0;
        m_ovf[i] = 0;
      end else if (ev[i] && m_en) begin
        if (m_cnt[i] == MAXC) m_ovf[i] = 1;
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_en = new_en;
  endtask

  // One clock: model consumes the inputs now on the pins, then outputs are checked.
  task automatic step();
    if (avs.avs_read) exp_rd = model_read(avs.avs_address);
    exp_rdv = avs.avs_read;
    model_update();
    @(posedge clk);
    #1;
    check("readdatavalid", 32'(avs.avs_readdatavalid), 32'(exp_rdv));
    check("readdata", avs.avs_readdata, exp_rd);
  endtask

  task automatic idle();
    msg_valid = 0; msg_ready = 0;
    adder_valid = 0; adder_ready = 0;
    remover_valid = 0; remover_ready = 0;
    avs.avs_read = 0; avs.avs_write = 0;
    avs.avs_address = 0; avs.avs_writedata = 0;
  endtask

  task automatic stage_events(input int stage, input int n);
    for (int c = 0; c < n; c++) begin
      idle();
      if (stage == 0) begin msg_valid = 1; msg_ready = 1; end
      if (stage == 1) begin adder_valid = 1; adder_ready = 1; end
      if (stage == 2) begin remover_valid = 1; remover_ready = 1; end
      step();
    end
    idle();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    idle();
    avs.avs_write = 1; avs.avs_address = a; avs.avs_writedata = d;
    step();
    idle();
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] lit);
    idle();
    avs.avs_read = 1; avs.avs_address = a;
    step();
    check(tag, avs.avs_readdata, lit);
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdv", 32'(avs.avs_readdatavalid), 32'd0);
    check("reset_rdata", avs.avs_readdata, 32'd0);
    check("waitrequest", 32'(avs.avs_waitrequest), 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int unsigned pick;
    int unsigned k;
    idle();
    model_reset();
    do_reset();

    bus_read("t1_msg", 32'h1000, 32'd0);
    bus_read("t1_adder", 32'h1004, 32'd0);
    bus_read("t1_rem", 32'h1008, 32'd0);
    bus_read("t1_ctrl", 32'h100C, 32'd1);

    stage_events(0, 5);
    stage_events(1, 3);
    for (int c = 0; c < 2; c++) begin
      idle(); adder_valid = 1; adder_ready = 0; step();
    end
    bus_read("t2_msg", 32'h1000, 32'd5);
    bus_read("t2_adder", 32'h1004, 32'd3);
    bus_read("t2_rem", 32'h1008, 32'd0);

    stage_events(2, 300);
    bus_read("t3_sat", 32'h1008, 32'h8000_00FF);
    bus_write(32'h1008, 32'h1234_5678);
    bus_read("t3_clr", 32'h1008, 32'd0);

    bus_write(32'h100C, 32'd0);
    stage_events(0, 4);
    bus_read("t4_off", 32'h1000, 32'd5);
    bus_write(32'h100C, 32'd1);
    stage_events(0, 4);
    bus_read("t4_on", 32'h1000, 32'd9);

    bus_write(32'h1000, 32'd0);
    stage_events(0, 7);
    idle();
    msg_valid = 1; msg_ready = 1;
    avs.avs_write = 1; avs.avs_address = 32'h1000; avs.avs_writedata = 32'hFFFF_FFFF;
    step();
    bus_read("t5_clr_ev", 32'h1000, 32'd1);
    stage_events(1, 2);
    bus_write(32'h100C, 32'h3);
    bus_read("t5_all_msg", 32'h1000, 32'd0);
    bus_read("t5_all_adder", 32'h1004, 32'd0);
    bus_read("t5_ctrl", 32'h100C, 32'd1);

    // Same-cycle read+write on one register returns the pre-write value.
    stage_events(2, 6);
    idle();
    avs.avs_read = 1; avs.avs_write = 1; avs.avs_address = 32'h1008;
    step();
    check("rw_same", avs.avs_readdata, 32'd6);
    bus_read("rw_after", 32'h1008, 32'd0);

    bus_read("t6_miss", 32'h2000, 32'd0);
    bus_read("t6_unal", 32'h1001, 32'd0);
    stage_events(0, 3);
    idle();
    avs.avs_read = 1; avs.avs_address = 32'h1000;
    step();
    avs.avs_read = 1; avs.avs_address = 32'h1000;
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    check("t6_rd_in_rst", 32'(avs.avs_readdatavalid), 32'd0);
    check("t6_rdata_rst", avs.avs_readdata, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1;
    bus_read("t6_post", 32'h1000, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      idle();
      msg_valid = 1'($urandom_range(0, 1)); msg_ready = 1'($urandom_range(0, 1));
      adder_valid = 1'($urandom_range(0, 1)); adder_ready = 1'($urandom_range(0, 1));
      remover_valid = 1'($urandom_range(0, 1)); remover_ready = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 5);
      k = $urandom_range(0, 3);
      if (pick < 4) avs.avs_address = 32'h1000 + 4 * k;
      else if (pick == 4) avs.avs_address = 32'h1000 + 4 * k + $urandom_range(1, 3);
      else avs.avs_address = $urandom;
      avs.avs_read = 1'($urandom_range(0, 1));
      avs.avs_write = ($urandom_range(0, 29) == 0);
      avs.avs_writedata = $urandom;
      if (avs.avs_address == 32'h100C) avs.avs_writedata[0] = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      avs.avs_read = 1; avs.avs_address = 32'h1000 + 4 * i;
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
